// File: rtl/nn_param_loader.sv
// Runtime parameter loader: parses the host word stream (header, count, weights, bias)
// into broadcast weight/bias strobes with stable layer/neuron selectors.
module nn_param_loader #(
    parameter int unsigned max_weights   = 784,
    parameter int unsigned total_neurons = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        clr_err,
    output logic [31:0] weight_value,
    output logic        valid_weight,
    output logic [31:0] bias_value,
    output logic        valid_bias,
    output logic [31:0] neuron_layer_no,
    output logic [31:0] neuron_neuron_no,
    output logic        busy,
    output logic        pkt_done,
    output logic        err,
    output logic [15:0] neurons_loaded,
    output logic        all_loaded
);

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        CNT  = 2'd1,
        WGT  = 2'd2,
        BIAS = 2'd3
    } state_t;

    state_t      state_r;
    logic        ready_r;
    logic [15:0] cnt_r;
    logic [31:0] weight_value_r;
    logic        valid_weight_r;
    logic [31:0] bias_value_r;
    logic        valid_bias_r;
    logic [31:0] layer_r;
    logic [31:0] neuron_r;
    logic        busy_r;
    logic        pkt_done_r;
    logic        err_r;
    logic [15:0] loaded_r;
    logic        all_loaded_r;

    logic        accept_s;
    logic [15:0] count_s;
    logic        bad_count_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Word acceptance and legality of the count field
    always_comb begin
        accept_s    = s_valid & ready_r;
        count_s     = s_data[15:0];
        bad_count_s = (count_s == 16'd0) || ({16'd0, count_s} > 32'(max_weights));
    end

    // Packet parser FSM with registered strobes, selectors and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= HDR;
            ready_r        <= 1'b0;
            cnt_r          <= 16'd0;
            weight_value_r <= 32'd0;
            valid_weight_r <= 1'b0;
            bias_value_r   <= 32'd0;
            valid_bias_r   <= 1'b0;
            layer_r        <= 32'd0;
            neuron_r       <= 32'd0;
            busy_r         <= 1'b0;
            pkt_done_r     <= 1'b0;
            err_r          <= 1'b0;
            loaded_r       <= 16'd0;
            all_loaded_r   <= 1'b0;
        end else begin
            ready_r        <= 1'b1;
            valid_weight_r <= 1'b0;
            valid_bias_r   <= 1'b0;
            pkt_done_r     <= 1'b0;
            err_r          <= err_r & ~clr_err;
            all_loaded_r   <= ({16'd0, loaded_r} >= 32'(total_neurons));
            if (accept_s) begin
                case (state_r)
                    HDR: begin
                        layer_r  <= {16'd0, s_data[31:16]};
                        neuron_r <= {16'd0, s_data[15:0]};
                        busy_r   <= 1'b1;
                        state_r  <= CNT;
                    end
                    CNT: begin
                        if (bad_count_s) begin
                            // Set wins over a simultaneous clr_err
                            err_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= HDR;
                        end else begin
                            cnt_r   <= count_s;
                            state_r <= WGT;
                        end
                    end
                    WGT: begin
                        weight_value_r <= s_data;
                        valid_weight_r <= 1'b1;
                        cnt_r          <= cnt_r - 16'd1;
                        if (cnt_r == 16'd1) begin
                            state_r <= BIAS;
                        end else begin
                            state_r <= WGT;
                        end
                    end
                    BIAS: begin
                        // busy stays high through the bias strobe cycle
                        bias_value_r <= s_data;
                        valid_bias_r <= 1'b1;
                        pkt_done_r   <= 1'b1;
                        loaded_r     <= sat_inc16(loaded_r);
                        state_r      <= HDR;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= HDR;
                    end
                endcase
            end else if (state_r == HDR) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    assign s_ready          = ready_r;
    assign weight_value     = weight_value_r;
    assign valid_weight     = valid_weight_r;
    assign bias_value       = bias_value_r;
    assign valid_bias       = valid_bias_r;
    assign neuron_layer_no  = layer_r;
    assign neuron_neuron_no = neuron_r;
    assign busy             = busy_r;
    assign pkt_done         = pkt_done_r;
    assign err              = err_r;
    assign neurons_loaded   = loaded_r;
    assign all_loaded       = all_loaded_r;

endmodule

// File: tb/tb_nn_param_loader.sv
// Self-checking bench for nn_param_loader: randomized packets against a packet-level
// model of the expected strobe sequence, plus a small neuron fed by the loader.
module tb_nn_param_loader;

    localparam int MAXW  = 784;
    localparam int TOTAL = 3;

    logic        clk;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        clr_err;
    logic [31:0] weight_value;
    logic        valid_weight;
    logic [31:0] bias_value;
    logic        valid_bias;
    logic [31:0] neuron_layer_no;
    logic [31:0] neuron_neuron_no;
    logic        busy;
    logic        pkt_done;
    logic        err;
    logic [15:0] neurons_loaded;
    logic        all_loaded;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_loaded;
    logic [31:0] last_wv;
    logic [31:0] last_bv;
    logic [31:0] wq[$];

    // Neuron instance model fed by the broadcast bus (layer 1, neuron 0)
    logic [31:0] nrn_w[4];
    logic [2:0]  nrn_waddr;
    logic [31:0] nrn_b;
    logic [31:0] nrn_acc;
    logic [1:0]  nrn_idx;
    logic        nrn_in_valid;
    logic [31:0] nrn_x;
    logic [31:0] nrn_out;
    int          wstrobe_cnt;

    nn_param_loader #(.max_weights(MAXW), .total_neurons(TOTAL)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .clr_err(clr_err), .weight_value(weight_value), .valid_weight(valid_weight),
        .bias_value(bias_value), .valid_bias(valid_bias), .neuron_layer_no(neuron_layer_no),
        .neuron_neuron_no(neuron_neuron_no), .busy(busy), .pkt_done(pkt_done), .err(err),
        .neurons_loaded(neurons_loaded), .all_loaded(all_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Neuron write port, MAC datapath and strobe counter
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            nrn_waddr   <= 3'd0;
            nrn_b       <= 32'd0;
            nrn_acc     <= 32'd0;
            nrn_idx     <= 2'd0;
            wstrobe_cnt <= 0;
        end else begin
            if (valid_weight) wstrobe_cnt <= wstrobe_cnt + 1;
            if (valid_weight && neuron_layer_no == 32'd1 && neuron_neuron_no == 32'd0 && nrn_waddr < 3'd4) begin
                nrn_w[nrn_waddr[1:0]] <= weight_value;
                nrn_waddr <= nrn_waddr + 3'd1;
            end
            if (valid_bias && neuron_layer_no == 32'd1 && neuron_neuron_no == 32'd0) nrn_b <= bias_value;
            if (nrn_in_valid) begin
                nrn_acc <= nrn_acc + nrn_x * nrn_w[nrn_idx];
                nrn_idx <= nrn_idx + 2'd1;
            end
        end
    end
    assign nrn_out = nrn_acc + nrn_b;

    function automatic logic [150:0] all_outs();
        return {s_ready, valid_weight, valid_bias, pkt_done, busy, err, all_loaded, neurons_loaded,
                weight_value, bias_value, neuron_layer_no, neuron_neuron_no};
    endfunction

    task automatic idle(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (valid_weight !== 1'b0 || valid_bias !== 1'b0 || pkt_done !== 1'b0 ||
                weight_value !== last_wv || bias_value !== last_bv) begin
                n_fail++;
                $display("FAIL %s_idle: vw=%b vb=%b pd=%b wv=%h bv=%h required 0 0 0 %h %h",
                         tag, valid_weight, valid_bias, pkt_done, weight_value, bias_value, last_wv, last_bv);
            end
        end
    endtask

    task automatic drive_word(input logic [31:0] w);
        s_data  = w;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    // Sends header/count/wq/bias; gap < 0 means random 0..2 idle cycles after each word
    task automatic send_pkt(input logic [15:0] layer, input logic [15:0] neuron,
                            input logic [31:0] bias, input int gap, input string tag);
        logic [31:0] words[$];
        int          n;
        int          prev_loaded;
        logic        exp_vw;
        logic        exp_vb;
        n = wq.size();
        words = {};
        words.push_back({layer, neuron});
        words.push_back({16'($urandom), 16'(n)});
        foreach (wq[i]) words.push_back(wq[i]);
        words.push_back(bias);
        for (int k = 0; k < words.size(); k++) begin
            drive_word(words[k]);
            prev_loaded = exp_loaded;
            exp_vw = (k >= 2) && (k <= n + 1);
            exp_vb = (k == n + 2);
            if (exp_vw) last_wv = wq[k-2];
            if (exp_vb) begin
                last_bv = bias;
                if (exp_loaded < 65535) exp_loaded++;
            end
            n_checks++;
            if (valid_weight !== exp_vw || weight_value !== last_wv) begin
                n_fail++;
                $display("FAIL %s_weight word%0d: vw=%b wv=%h required %b %h", tag, k, valid_weight, weight_value, exp_vw, last_wv);
            end
            n_checks++;
            if (valid_bias !== exp_vb || pkt_done !== exp_vb || bias_value !== last_bv) begin
                n_fail++;
                $display("FAIL %s_bias word%0d: vb=%b pd=%b bv=%h required %b %b %h", tag, k, valid_bias, pkt_done, bias_value, exp_vb, exp_vb, last_bv);
            end
            n_checks++;
            if (neuron_layer_no !== {16'd0, layer} || neuron_neuron_no !== {16'd0, neuron} || busy !== 1'b1 ||
                neurons_loaded !== 16'(exp_loaded) || all_loaded !== (prev_loaded >= TOTAL)) begin
                n_fail++;
                $display("FAIL %s_status word%0d: sel=%0d/%0d busy=%b loaded=%0d all=%b required %0d/%0d 1 %0d %b",
                         tag, k, neuron_layer_no, neuron_neuron_no, busy, neurons_loaded, all_loaded,
                         layer, neuron, exp_loaded, prev_loaded >= TOTAL);
            end
            idle((gap < 0) ? int'($urandom_range(2, 0)) : gap, tag);
        end
    endtask

    task automatic do_reset(input string tag);
        logic [150:0] exp_o;
        rst = 1'b1; s_valid = 1'b0; clr_err = 1'b0; nrn_in_valid = 1'b0; s_data = 32'd0;
        #7;
        n_checks++;
        if (all_outs() !== 151'd0) begin
            n_fail++;
            $display("FAIL %s_in_reset: outputs=%h required 0", tag, all_outs());
        end
        @(negedge clk);
        rst = 1'b0;
        exp_loaded = 0; last_wv = 32'd0; last_bv = 32'd0;
        @(posedge clk); #1;
        exp_o = '0;
        exp_o[150] = 1'b1;
        n_checks++;
        if (all_outs() !== exp_o) begin
            n_fail++;
            $display("FAIL %s_after_reset: outputs=%h required %h", tag, all_outs(), exp_o);
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_basic();
        do_reset("basic");
        wq = {32'h11, 32'h22, 32'h33};
        send_pkt(16'd2, 16'd5, 32'h0000_0100, 0, "basic");
        idle(2, "basic_tail");
        n_checks++;
        if (busy !== 1'b0 || neurons_loaded !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_end: busy=%b loaded=%0d required 0 1", busy, neurons_loaded);
        end
    endtask

    task automatic test_gapped();
        do_reset("gapped");
        wq = {32'h11, 32'h22, 32'h33};
        send_pkt(16'd2, 16'd5, 32'h0000_0100, 2, "gapped");
    endtask

    task automatic test_back_to_back_random();
        int n;
        do_reset("random");
        for (int p = 0; p < 6; p++) begin
            n = $urandom_range(8, 1);
            wq = {};
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            send_pkt(16'($urandom), 16'($urandom), $urandom, (p % 2 == 0) ? 0 : -1, "random");
        end
    endtask

    task automatic test_bad_count();
        do_reset("badcnt");
        drive_word({16'd3, 16'd4});
        drive_word({16'h5A5A, 16'd0});
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || valid_weight !== 1'b0 || valid_bias !== 1'b0 || pkt_done !== 1'b0) begin
            n_fail++;
            $display("FAIL badcnt_zero: err=%b busy=%b vw=%b vb=%b pd=%b required 1 0 0 0 0", err, busy, valid_weight, valid_bias, pkt_done);
        end
        wq = {$urandom, $urandom};
        send_pkt(16'd3, 16'd4, $urandom, 0, "badcnt_resync");
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL badcnt_sticky: err=%b required 1", err);
        end
        clr_err = 1'b1;
        idle(1, "badcnt_clr");
        clr_err = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL badcnt_clear: err=%b required 0", err);
        end
        drive_word({16'd6, 16'd1});
        s_data = {16'hFFFF, 16'(MAXW + 1)}; s_valid = 1'b1; clr_err = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; clr_err = 1'b0;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0 || valid_weight !== 1'b0 || pkt_done !== 1'b0) begin
            n_fail++;
            $display("FAIL badcnt_785_set_wins: err=%b busy=%b vw=%b pd=%b required 1 0 0 0", err, busy, valid_weight, pkt_done);
        end
        wq = {$urandom};
        send_pkt(16'd6, 16'd1, $urandom, -1, "badcnt_after785");
    endtask

    task automatic test_full_load();
        int sizes[3] = '{784, 784, 10};
        do_reset("full");
        for (int p = 0; p < 3; p++) begin
            wq = {};
            for (int i = 0; i < sizes[p]; i++) wq.push_back($urandom);
            send_pkt(16'd0, 16'(p), $urandom, (p == 2) ? 0 : -1, "full");
        end
        n_checks++;
        if (wstrobe_cnt !== 1578) begin
            n_fail++;
            $display("FAIL full_strobe_count: got %0d required 1578", wstrobe_cnt);
        end
        @(posedge clk); #1;
        n_checks++;
        if (all_loaded !== 1'b1 || neurons_loaded !== 16'd3) begin
            n_fail++;
            $display("FAIL full_all_loaded: all=%b loaded=%0d required 1 3", all_loaded, neurons_loaded);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [150:0] exp_o;
        do_reset("midrst");
        drive_word({16'd7, 16'd9});
        drive_word(32'd3);
        drive_word($urandom);
        drive_word($urandom);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (all_outs() !== 151'd0) begin
            n_fail++;
            $display("FAIL midrst_async_clear: outputs=%h required 0", all_outs());
        end
        @(negedge clk);
        rst = 1'b0;
        exp_loaded = 0; last_wv = 32'd0; last_bv = 32'd0;
        @(posedge clk); #1;
        exp_o = '0;
        exp_o[150] = 1'b1;
        n_checks++;
        if (all_outs() !== exp_o) begin
            n_fail++;
            $display("FAIL midrst_release: outputs=%h required %h", all_outs(), exp_o);
        end
        wq = {$urandom, $urandom, $urandom};
        send_pkt(16'd1, 16'd0, $urandom, -1, "midrst_new");
    endtask

    task automatic test_neuron_cosim();
        logic [31:0] x[4];
        logic [31:0] bias;
        logic [31:0] ref_out;
        do_reset("cosim");
        wq = {};
        for (int i = 0; i < 4; i++) wq.push_back(32'($urandom_range(255, 0)));
        bias = 32'($urandom_range(65535, 0));
        send_pkt(16'd1, 16'd0, bias, -1, "cosim");
        ref_out = bias;
        for (int i = 0; i < 4; i++) begin
            x[i] = 32'($urandom_range(255, 0));
            ref_out = ref_out + x[i] * wq[i];
        end
        for (int i = 0; i < 4; i++) begin
            nrn_x = x[i];
            nrn_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        nrn_in_valid = 1'b0;
        n_checks++;
        if (nrn_out !== ref_out) begin
            n_fail++;
            $display("FAIL cosim_neuron_out: got %h required %h", nrn_out, ref_out);
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 32'd0; clr_err = 1'b0;
        nrn_in_valid = 1'b0; nrn_x = 32'd0;
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back_random();
        test_bad_count();
        test_full_load();
        test_reset_mid_packet();
        test_neuron_cosim();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
